// File: rtl/bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : bus_fabric
// Brief    : CPU-to-slave bus fabric. Decodes the upper address bits into a
//            registered one-hot chip select and waits for the selected slave's
//            ready. Adds a bus timeout, an unmapped-region error and a sticky
//            error-capture register.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module bus_fabric #(
  parameter int          AW       = 16,
  parameter int          DW       = 16,
  parameter int          SEL_BITS = 2,
  parameter int          N_SLAVES = 4,
  parameter int          TIMEOUT  = 15,
  parameter logic [DW-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_req,
  input  logic                   m_write,
  input  logic [AW-1:0]          m_addr,
  input  logic [DW-1:0]          m_wdata,
  output logic [DW-1:0]          m_rdata,
  output logic                   m_ready,
  output logic                   m_err,
  output logic                   m_busy,
  output logic [N_SLAVES-1:0]    s_cs,
  output logic                   s_write,
  output logic [AW-SEL_BITS-1:0] s_addr,
  output logic [DW-1:0]          s_wdata,
  input  logic [N_SLAVES*DW-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]    s_ready,
  output logic                   err_valid,
  output logic [AW-1:0]          err_addr,
  input  logic                   err_clr
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [N_SLAVES-1:0]     s_cs_q, s_cs_d;
  logic                    s_write_q, s_write_d;
  logic [AW-SEL_BITS-1:0]  s_addr_q, s_addr_d;
  logic [DW-1:0]           s_wdata_q, s_wdata_d;
  logic [DW-1:0]           m_rdata_q, m_rdata_d;
  logic                    m_ready_q, m_ready_d;
  logic                    m_err_q, m_err_d;
  logic                    m_busy_q, m_busy_d;
  logic                    err_valid_q, err_valid_d;
  logic [AW-1:0]           err_addr_q, err_addr_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    wr_q, wr_d;
  logic [AW-1:0]           addr_q, addr_d;

  logic [SEL_BITS-1:0]     idx;
  logic                    mapped;
  logic [N_SLAVES-1:0]     onehot;
  logic                    sel_ready;
  logic [DW-1:0]           sel_rdata;
  logic                    set_err;
  logic [AW-1:0]           err_src;

  // Decode the requested slave index and whether it is implemented
  always_comb begin
    idx    = m_addr[AW-1 -: SEL_BITS];
    mapped = (32'(idx) < N_SLAVES);
    onehot = N_SLAVES'(1) << idx;
  end

  // Observe only the selected slave: chip select is one-hot and stable in WAIT
  always_comb begin
    sel_ready = |(s_ready & s_cs_q);
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_cs_q[i]) sel_rdata = s_rdata[i*DW +: DW];
    end
  end

  // Next-state logic; every output is computed here and registered below
  always_comb begin
    state_d     = state_q;
    s_cs_d      = s_cs_q;
    s_write_d   = s_write_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    m_rdata_d   = m_rdata_q;
    m_ready_d   = 1'b0;
    m_err_d     = 1'b0;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    timer_d     = timer_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    set_err     = 1'b0;
    err_src     = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          wr_d      = m_write;
          addr_d    = m_addr;
          s_addr_d  = m_addr[AW-SEL_BITS-1:0];
          s_wdata_d = m_wdata;
          if (mapped) begin
            s_cs_d    = onehot;
            s_write_d = m_write;
            timer_d   = TW'(1);
            state_d   = ST_WAIT;
          end else begin
            // Unmapped: respond with an error next cycle, no slave touched
            state_d   = ST_RESP;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            if (!m_write) m_rdata_d = ERR_DATA;
            set_err   = 1'b1;
            err_src   = m_addr;
          end
        end
      end
      ST_WAIT: begin
        // Ready is checked before timeout so a last-cycle ready still succeeds
        if (sel_ready) begin
          if (!wr_q) m_rdata_d = sel_rdata;
          state_d   = ST_RESP;
          m_ready_d = 1'b1;
          s_cs_d    = '0;
          s_write_d = 1'b0;
        end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT)) begin
          if (!wr_q) m_rdata_d = ERR_DATA;
          state_d   = ST_RESP;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          s_cs_d    = '0;
          s_write_d = 1'b0;
          set_err   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sticky capture: only the first error's address is kept; set beats clear
    if (set_err) begin
      err_valid_d = 1'b1;
      if (!err_valid_q) err_addr_d = err_src;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end

    m_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_cs_q      <= '0;
      s_write_q   <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      m_rdata_q   <= '0;
      m_ready_q   <= 1'b0;
      m_err_q     <= 1'b0;
      m_busy_q    <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      timer_q     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      s_cs_q      <= s_cs_d;
      s_write_q   <= s_write_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      m_rdata_q   <= m_rdata_d;
      m_ready_q   <= m_ready_d;
      m_err_q     <= m_err_d;
      m_busy_q    <= m_busy_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      timer_q     <= timer_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
    end
  end

  assign m_rdata   = m_rdata_q;
  assign m_ready   = m_ready_q;
  assign m_err     = m_err_q;
  assign m_busy    = m_busy_q;
  assign s_cs      = s_cs_q;
  assign s_write   = s_write_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_fabric
// Brief    : Scoreboard bench for bus_fabric with three implemented slaves
//            (index 3 unmapped) and latency-programmable slave models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_write, err_clr;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_rdata;
  logic        m_ready, m_err, m_busy;
  logic [2:0]  s_cs;
  logic        s_write;
  logic [13:0] s_addr;
  logic [15:0] s_wdata;
  logic [47:0] s_rdata;
  logic [2:0]  s_ready;
  logic        err_valid;
  logic [15:0] err_addr;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          ready_count = 0;
  int          cyc = 0;
  int          lat [3];
  logic [2:0]  noise;
  int          cs_cnt;
  logic [15:0] hold;

  bus_fabric #(
    .AW(16), .DW(16), .SEL_BITS(2), .N_SLAVES(3), .TIMEOUT(15), .ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .m_busy(m_busy),
    .s_cs(s_cs), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  assign s_rdata = {16'h2222, 16'h1234, 16'h0A0A};

  // Cycles the current chip select has been held
  always @(posedge clk or posedge rst) begin
    if (rst) cs_cnt <= 0;
    else if (s_cs == 3'b000) cs_cnt <= 0;
    else cs_cnt <= cs_cnt + 1;
  end

  // Slave i is ready in its lat[i]-th selected cycle (0 = never); noise hits other bits
  always_comb begin
    s_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      s_ready[i] = (s_cs[i] && lat[i] != 0 && (cs_cnt + 1) >= lat[i]) || noise[i];
    end
  end

  // Response monitor: every m_ready pulse pops one expectation
  always @(negedge clk) begin
    if (!rst && m_ready) begin
      ready_count++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ready: m_ready with empty scoreboard, err=%0b rdata=%h", m_err, m_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({m_err, m_rdata} !== {e.err, e.rdata}) begin
          miscompares++;
          $display("FAIL response: got err=%0b rdata=%h, want err=%0b rdata=%h",
                   m_err, m_rdata, e.err, e.rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one request strobe; returns in cycle 1 (first cycle after acceptance)
  task automatic send(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
    m_req   = 1'b1;
    m_write = wr;
    m_addr  = addr;
    m_wdata = wd;
    cyc     = 0;
    step();
    m_req   = 1'b0;
  endtask

  task automatic wait_ready();
    while (!m_ready && cyc < 40) step();
    if (!m_ready) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 0; m_write = 0; m_addr = 0; m_wdata = 0; err_clr = 0;
    noise = 3'b000; lat[0] = 0; lat[1] = 0; lat[2] = 0; hold = 16'h0000;
    #3;
    vectors++;
    if ({s_cs, s_write, s_addr, s_wdata, m_rdata, m_ready, m_err, m_busy, err_valid, err_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: outputs=%h, want all zero",
               {s_cs, s_write, s_addr, s_wdata, m_rdata, m_ready, m_err, m_busy, err_valid, err_addr});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    vectors++;
    if (m_busy !== 1'b0 || s_cs !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%0b cs=%b, want 0/000", m_busy, s_cs);
    end
  endtask

  task automatic test_read_zero_wait();
    lat[1] = 1;
    sb.push_back('{err: 1'b0, rdata: 16'h1234});
    send(1'b0, 16'h4012, 16'h0000);
    vectors++;
    if (s_cs !== 3'b010 || s_addr !== 14'h0012 || s_write !== 1'b0) begin
      miscompares++;
      $display("FAIL read0_cycle1: cs=%b addr=%h wr=%0b, want 010/0012/0", s_cs, s_addr, s_write);
    end
    wait_ready();
    vectors++;
    if (cyc !== 2 || m_err !== 1'b0 || m_rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL read0_latency: cycle=%0d err=%0b rdata=%h, want 2/0/1234", cyc, m_err, m_rdata);
    end
    hold = 16'h1234;
    step();
    vectors++;
    if (m_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read0_busy: busy=%0b, want 0", m_busy);
    end
  endtask

  task automatic test_write_wait();
    lat[0] = 3;
    noise  = 3'b110;
    sb.push_back('{err: 1'b0, rdata: hold});
    send(1'b1, 16'h0005, 16'hA5A5);
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if (s_cs !== 3'b001 || s_wdata !== 16'hA5A5 || s_write !== 1'b1 || s_addr !== 14'h0005) begin
        miscompares++;
        $display("FAIL write_hold c%0d: cs=%b wdata=%h wr=%0b addr=%h, want 001/a5a5/1/0005",
                 c, s_cs, s_wdata, s_write, s_addr);
      end
      if (c < 3) step();
    end
    wait_ready();
    noise = 3'b000;
    vectors++;
    if (cyc !== 4 || m_err !== 1'b0 || m_rdata !== hold || s_cs !== 3'b000) begin
      miscompares++;
      $display("FAIL write_latency: cycle=%0d err=%0b rdata=%h cs=%b, want 4/0/%h/000",
               cyc, m_err, m_rdata, s_cs, hold);
    end
    step();
  endtask

  task automatic test_timeout();
    lat[2] = 0;
    sb.push_back('{err: 1'b1, rdata: 16'hDEAD});
    send(1'b0, 16'h8000, 16'h0000);
    for (int c = 1; c <= 15; c++) begin
      vectors++;
      if (s_cs !== 3'b100 || m_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_wait c%0d: cs=%b ready=%0b, want 100/0", c, s_cs, m_ready);
      end
      if (c < 15) step();
    end
    wait_ready();
    vectors++;
    if (cyc !== 16 || m_err !== 1'b1 || m_rdata !== 16'hDEAD || err_valid !== 1'b1 || err_addr !== 16'h8000) begin
      miscompares++;
      $display("FAIL timeout_resp: cycle=%0d err=%0b rdata=%h ev=%0b ea=%h, want 16/1/dead/1/8000",
               cyc, m_err, m_rdata, err_valid, err_addr);
    end
    step();
    // Ready on the final allowed cycle still succeeds
    lat[2] = 15;
    sb.push_back('{err: 1'b0, rdata: 16'h2222});
    send(1'b0, 16'h8002, 16'h0000);
    wait_ready();
    vectors++;
    if (cyc !== 16 || m_err !== 1'b0 || m_rdata !== 16'h2222) begin
      miscompares++;
      $display("FAIL timeout_edge: cycle=%0d err=%0b rdata=%h, want 16/0/2222", cyc, m_err, m_rdata);
    end
    hold = 16'h2222;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    vectors++;
    if (err_valid !== 1'b0 || err_addr !== 16'h8000) begin
      miscompares++;
      $display("FAIL timeout_clear: ev=%0b ea=%h, want 0/8000", err_valid, err_addr);
    end
  endtask

  task automatic test_unmapped();
    sb.push_back('{err: 1'b1, rdata: 16'hDEAD});
    send(1'b0, 16'hC000, 16'h0000);
    vectors++;
    if (s_cs !== 3'b000 || cyc !== 1 || m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 16'hDEAD) begin
      miscompares++;
      $display("FAIL unmapped_resp: cs=%b cycle=%0d ready=%0b err=%0b rdata=%h, want 000/1/1/1/dead",
               s_cs, cyc, m_ready, m_err, m_rdata);
    end
    vectors++;
    if (err_valid !== 1'b1 || err_addr !== 16'hC000) begin
      miscompares++;
      $display("FAIL unmapped_capture: ev=%0b ea=%h, want 1/c000", err_valid, err_addr);
    end
    hold = 16'hDEAD;
    step();
    // Back-to-back: second error right after the first response
    sb.push_back('{err: 1'b1, rdata: 16'hDEAD});
    send(1'b0, 16'hC100, 16'h0000);
    wait_ready();
    vectors++;
    if (cyc !== 1 || err_addr !== 16'hC000 || err_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL unmapped_second: cycle=%0d ea=%h ev=%0b, want 1/c000/1", cyc, err_addr, err_valid);
    end
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    vectors++;
    if (err_valid !== 1'b0 || err_addr !== 16'hC000) begin
      miscompares++;
      $display("FAIL err_clr: ev=%0b ea=%h, want 0/c000", err_valid, err_addr);
    end
    // New error coinciding with err_clr: set wins and a fresh address is captured
    err_clr = 1'b1;
    sb.push_back('{err: 1'b1, rdata: 16'hDEAD});
    send(1'b0, 16'hC200, 16'h0000);
    err_clr = 1'b0;
    vectors++;
    if (err_valid !== 1'b1 || err_addr !== 16'hC200) begin
      miscompares++;
      $display("FAIL set_beats_clr: ev=%0b ea=%h, want 1/c200", err_valid, err_addr);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    lat[1] = 0;
    send(1'b0, 16'h4000, 16'h0000);
    step();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({s_cs, s_write, s_addr, s_wdata, m_rdata, m_ready, m_err, m_busy, err_valid, err_addr} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: outputs=%h, want all zero",
               {s_cs, s_write, s_addr, s_wdata, m_rdata, m_ready, m_err, m_busy, err_valid, err_addr});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    hold = 16'h0000;
    lat[1] = 1;
    sb.push_back('{err: 1'b0, rdata: 16'h1234});
    send(1'b0, 16'h4003, 16'h0000);
    wait_ready();
    vectors++;
    if (cyc !== 2 || m_err !== 1'b0 || m_rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL after_reset_read: cycle=%0d err=%0b rdata=%h, want 2/0/1234", cyc, m_err, m_rdata);
    end
    hold = 16'h1234;
    step();
  endtask

  task automatic test_ignored_req();
    int base;
    base   = ready_count;
    lat[0] = 4;
    sb.push_back('{err: 1'b0, rdata: 16'h0A0A});
    send(1'b0, 16'h0010, 16'h0000);
    // Requests while busy must be dropped
    m_req = 1'b1; m_addr = 16'h4000; m_write = 1'b1;
    step();
    step();
    m_req = 1'b0; m_write = 1'b0;
    vectors++;
    if (s_cs !== 3'b001 || s_addr !== 14'h0010 || s_write !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_hold: cs=%b addr=%h wr=%0b, want 001/0010/0", s_cs, s_addr, s_write);
    end
    wait_ready();
    // Request during the response cycle is also dropped
    m_req = 1'b1; m_addr = 16'h4001;
    step();
    m_req = 1'b0;
    vectors++;
    if (cyc !== 6 || m_busy !== 1'b0 || s_cs !== 3'b000) begin
      miscompares++;
      $display("FAIL ignored_resp: cycle=%0d busy=%0b cs=%b, want 6/0/000", cyc, m_busy, s_cs);
    end
    repeat (4) step();
    vectors++;
    if (ready_count - base !== 1 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL ignored_count: ready pulses=%0d pending=%0d, want 1/0", ready_count - base, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_unmapped();
    test_reset_mid_wait();
    test_ignored_req();
    repeat (2) step();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending=%0d, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the fixed 4-way chip-select decode and read-data mux used at SoC top level.
- Sits between CPU data port and N memory-mapped slaves (IO, RAM, future peripherals).
- Decodes upper address bits to a one-hot chip select, registers the request, and supports per-slave wait states via a ready handshake.
- Adds a bus timeout and an unmapped-region error, plus a sticky error-capture register.

Parameters:
- AW, 16, master address width.
- DW, 16, data width.
- SEL_BITS, 2, upper address bits used for slave select; slave index = m_addr[AW-1 -: SEL_BITS].
- N_SLAVES, 4, number of implemented slaves; must be <= 2**SEL_BITS. Indices >= N_SLAVES are unmapped.
- TIMEOUT, 15, maximum WAIT cycles before error; 0 disables timeout.
- ERR_DATA, 16'hDEAD, read data returned on any error; width DW.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  1  single-cycle request strobe; accepted only when m_busy=0.
- m_write  in  1  1=write, 0=read; sampled with m_req.
- m_addr  in  AW  byte/word address; sampled with m_req.
- m_wdata  in  DW  write data; sampled with m_req.
- m_rdata  out  DW  read data; valid while m_ready=1.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  qualifies m_ready: timeout or unmapped.
- m_busy  out  1  high whenever FSM not IDLE.
- s_cs  out  N_SLAVES  registered one-hot chip select.
- s_write  out  1  registered write strobe, broadcast to all slaves.
- s_addr  out  AW-SEL_BITS  registered offset address (low bits of m_addr).
- s_wdata  out  DW  registered write data.
- s_rdata  in  N_SLAVES*DW  flat read buses; slave i at [i*DW +: DW].
- s_ready  in  N_SLAVES  per-slave completion; only the selected bit is observed.
- err_valid  out  1  sticky: set on any error.
- err_addr  out  AW  m_addr of the first error since last clear.
- err_clr  in  1  clears err_valid; err_addr holds its value.

Behaviour:
- Reset (async, immediate): FSM=IDLE. s_cs=0, s_write=0, s_addr=0, s_wdata=0, m_rdata=0, m_ready=0, m_err=0, m_busy=0, err_valid=0, err_addr=0, timer=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on m_req=1, latch write, offset, wdata and index.
  - Mapped index: s_cs[index]=1 and s_write=m_write from next cycle; go to WAIT; timer=1.
  - Unmapped index: go to RESP with err=1; s_cs stays 0.
  - m_req in any other state is ignored, with no queuing.
- WAIT: s_cs/s_write/s_addr/s_wdata held stable.
  - s_ready[index]=1: capture s_rdata[index] into m_rdata (reads only; writes leave m_rdata unchanged); go to RESP; err=0.
  - Else if TIMEOUT!=0 and timer==TIMEOUT: go to RESP; err=1.
  - Else timer++.
  - Ready on the final cycle (timer==TIMEOUT) beats timeout.
- RESP: exactly one cycle.
  - m_ready=1; m_err=err; s_cs=0; s_write=0.
  - On err and read: m_rdata=ERR_DATA.
  - On err: err_valid=1; err_addr=latched m_addr only if err_valid was 0.
  - Next state: IDLE.
  - m_busy=0 in RESP's following cycle, so the earliest next m_req is the cycle after RESP.
- Latency, m_req at cycle 0:
  - Zero-wait slave (ready in first WAIT cycle): m_ready at cycle 2.
  - k-th WAIT cycle ready: m_ready at cycle k+1.
  - Timeout: m_ready at cycle TIMEOUT+1.
  - Unmapped: m_ready at cycle 1.
- err_clr and a new error in the same cycle: set wins.
- Timer width: clog2(TIMEOUT+1), minimum 1.
- Slave s_ready bits for non-selected indices are ignored.
- m_ready, m_err and s_cs are registered; no combinational path from m_* inputs to outputs.

Test Plan:
- Read, zero wait:
  - Stimulus: m_addr=16'h4012, m_req pulse; slave1 ties s_ready=1, rdata=16'h1234.
  - Response: cycle 1 s_cs=4'b0010, s_addr=14'h0012, s_write=0; cycle 2 m_ready=1, m_err=0, m_rdata=16'h1234; cycle 3 m_busy=0.
- Write with wait states:
  - Stimulus: m_addr=16'h0005, m_wdata=16'hA5A5, m_write=1; slave0 ready in the 3rd WAIT cycle.
  - Response: s_cs=4'b0001 and s_wdata=16'hA5A5 for cycles 1-3; m_ready at cycle 4, m_err=0; m_rdata unchanged.
- Timeout:
  - Stimulus: read 16'h8000; slave2 never ready; TIMEOUT=15.
  - Response: s_cs=4'b0100 for cycles 1-15; cycle 16 m_ready=1, m_err=1, m_rdata=16'hDEAD; err_valid=1, err_addr=16'h8000.
  - Second variant: ready on WAIT cycle 15 gives m_err=0.
- Unmapped, N_SLAVES=3:
  - Stimulus: read 16'hC000.
  - Response: s_cs stays 0; cycle 1 m_ready=1, m_err=1, m_rdata=16'hDEAD.
  - Then a second error at 16'hC100: err_addr stays 16'hC000; err_clr clears err_valid.
- Reset mid-WAIT and ignored request:
  - Stimulus: assert rst in WAIT cycle 2.
  - Response: all outputs 0 immediately, without a clock edge; after release, a fresh read completes normally.
  - Stimulus: m_req pulsed while m_busy=1.
  - Response: no extra transaction; exactly one m_ready observed.
